// File: rtl/lock_key_pkg.sv
// Shared types and constants for the serial key-provisioning receiver.
package lock_key_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PARITY = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  // Replicated across key_out whenever no checked key is being presented.
  localparam logic KEY_LOCKED_FILL = 1'b1;

endpackage

// File: rtl/key_shift_reg.sv
// MSB-first key shift register with running even parity and beat counter.
// last_o flags that the next shifted bit is the final key bit.
module key_shift_reg #(
  parameter int KEY_W = 64,
  parameter int CNT_W = $clog2(KEY_W + 1)
) (
  input  logic             CLK,
  input  logic             PRESET,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [KEY_W-1:0] data_o,
  output logic             par_o,
  output logic             last_o
);

  logic [KEY_W-1:0] sr_q, sr_d;
  logic             par_q, par_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority so a restart discards any beat in the same cycle.
  always_comb begin
    sr_d  = sr_q;
    par_d = par_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      sr_d  = '0;
      par_d = 1'b0;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = {sr_q[KEY_W-2:0], bit_i};
      par_d = par_q ^ bit_i;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge PRESET) begin
    if (PRESET) begin
      sr_q  <= '0;
      par_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      par_q <= par_d;
      cnt_q <= cnt_d;
    end
  end

  assign data_o = sr_q;
  assign par_o  = par_q;
  assign last_o = (cnt_q == CNT_W'(KEY_W - 1));

endmodule

// File: rtl/lock_key_receiver.sv
// Serial key receiver: KEY_W bits MSB first plus even parity over valid/ready.
// key_out stays at the locked fill value except while a parity-checked key is held.
module lock_key_receiver
  import lock_key_pkg::*;
#(
  parameter  int KEY_W = 64,
  localparam int CNT_W = $clog2(KEY_W + 1)
) (
  input  logic             CLK,
  input  logic             PRESET,
  input  logic             start,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy
);

  localparam logic [KEY_W-1:0] LOCKED_KEY = {KEY_W{KEY_LOCKED_FILL}};

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;

  logic             sr_clr, sr_shift, sr_last, sr_par;
  logic [KEY_W-1:0] sr_data;
  logic             rx_phase;

  assign rx_phase = (state_q == SHIFT) || (state_q == PARITY);

  key_shift_reg #(
    .KEY_W (KEY_W),
    .CNT_W (CNT_W)
  ) u_shift (
    .CLK     (CLK),
    .PRESET  (PRESET),
    .clr_i   (sr_clr),
    .shift_i (sr_shift),
    .bit_i   (s_data),
    .data_o  (sr_data),
    .par_o   (sr_par),
    .last_o  (sr_last)
  );

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    vld_d    = vld_q;
    err_d    = err_q;
    sr_clr   = 1'b0;
    sr_shift = 1'b0;
    if (start) begin
      // start wins over any beat and re-arms from every state.
      state_d = SHIFT;
      sr_clr  = 1'b1;
      key_d   = LOCKED_KEY;
      vld_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (s_valid) begin
            sr_shift = 1'b1;
            if (sr_last) state_d = PARITY;
          end
        end
        PARITY: begin
          if (s_valid) begin
            if ((sr_par ^ s_data) == 1'b0) begin
              state_d = DONE;
              key_d   = sr_data;
              vld_d   = 1'b1;
            end else begin
              state_d = ERROR;
              err_d   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      key_q   <= LOCKED_KEY;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign s_ready   = rx_phase;
  assign busy      = rx_phase;
  assign key_out   = key_q;
  assign key_valid = vld_q;
  assign key_err   = err_q;

endmodule
